rect_plotter: RTL and testbench
===============================

// Module: rect_plotter
// PURPOSE
//  Parametrised successor to the fixed 4x4 square drawer. Takes one rectangle request (origin, size, colour) and
//  streams one pixel per clock in raster order into the vga_adapter write port (x, y, colour, plot).
//  Adds a go/busy/done handshake, runtime size, screen-edge clipping and zero-size handling.
// PARAMETERS
//  X_W       8    width of x coordinate (160-wide screen)
//  Y_W       7    width of y coordinate (120-high screen)
//  COLOUR_W  3    colour bits per pixel
//  MAX_W     16   largest width accepted; larger requests saturate to MAX_W
//  MAX_H     16   largest height accepted; larger requests saturate to MAX_H
//  SCREEN_W  160  pixels with x >= SCREEN_W are clipped
//  SCREEN_H  120  pixels with y >= SCREEN_H are clipped
// PORTS
//  clk         in   1                   system clock (CLOCK_50 domain)
//  resetn      in   1                   synchronous, active-low reset
//  go          in   1                   start request; sampled only in IDLE
//  x_in        in   X_W                 rectangle origin x (left)
//  y_in        in   Y_W                 rectangle origin y (top)
//  w_in        in   $clog2(MAX_W+1)     width in pixels, 0 allowed
//  h_in        in   $clog2(MAX_H+1)     height in pixels, 0 allowed
//  colour_in   in   COLOUR_W            fill colour
//  outline     in   1                   only when RECT_OUTLINE_EN defined: 1 = draw border only
//  busy        out  1                   high from accepted go until done cycle inclusive
//  done        out  1                   single-cycle completion pulse
//  x_out       out  X_W                 pixel x to vga_adapter
//  y_out       out  Y_W                 pixel y to vga_adapter
//  colour_out  out  COLOUR_W            pixel colour to vga_adapter
//  plot        out  1                   write enable to vga_adapter
// BEHAVIOUR
//  - Reset: resetn low at a rising edge -> state IDLE; busy, done, plot, x_out, y_out, colour_out all 0 after that edge.
//    Applies mid-draw; the partial rectangle is abandoned, no done pulse.
//  - FSM IDLE -> DRAW -> DONE -> IDLE. All outputs registered.
//  - IDLE: go=1 latches x_in, y_in, saturated w/h, colour_in (and outline); go while busy is ignored, not queued.
//    w=0 or h=0 -> DONE directly (busy 1 cycle, done 1 cycle, zero plots).
//    Otherwise -> DRAW with xoff=yoff=0.
//  - DRAW: one pixel per cycle; first pixel registered on the edge after go was accepted (latency 1).
//    Order: xoff 0..w-1 for yoff 0, then yoff 1, ...; exactly w*h cycles in DRAW.
//    x_out = x0+xoff, y_out = y0+yoff, computed in X_W+1 / Y_W+1 bits; outputs carry the low X_W / Y_W bits.
//    plot = 1 unless the (X_W+1)-bit sum >= SCREEN_W or the (Y_W+1)-bit sum >= SCREEN_H (clipped:
//    plot=0, cycle still consumed, so latency is independent of position).
//  - Last pixel (xoff=w-1, yoff=h-1) -> DONE: plot=0, done=1, busy=1 for that cycle; -> IDLE next edge.
//  - IDLE: busy=0, done=0, plot=0; x_out/y_out/colour_out hold their last values.
//  - go accepted in the same cycle done is asserted is not possible (DONE is not IDLE); earliest restart is the
//    cycle after done.
// CONFIGURATION
//  RECT_OUTLINE_EN defined: port outline present; when latched 1, plot is additionally gated to pixels with
//    xoff==0, xoff==w-1, yoff==0 or yoff==h-1; interior pixels still consume a cycle with plot=0.
//  RECT_OUTLINE_EN undefined: port absent; every in-screen pixel is plotted (filled rectangle).
// STRUCTURE
//  - Shared package vga_pkg: SCREEN_W/SCREEN_H defaults, X_W/Y_W/COLOUR_W, named colour constants (BLACK..WHITE),
//    state enum typedef for the draw FSM.
//  - One sub-module rect_scan_counter: loadable xoff/yoff raster counter with w/h limits, outputs last_pixel
//    and edge flags (first_col, last_col, first_row, last_row). FSM, clipping and output registers stay in rect_plotter.
// TESTING
//  1 go, (x,y)=(37,85), w=h=4, colour=3'b100 -> 16 plot cycles starting 1 clk after go, (37,85)..(40,88)
//    raster order, done pulse on cycle 17, busy high cycles 1..17.
//  2 w=0,h=5 -> busy 1 cycle, done 1 cycle, zero plot pulses.
//  3 (x,y)=(158,118), w=h=4 -> 16 DRAW cycles, plot only at (158..159,118..119) = 4 pulses; no wrapped writes.
//  4 w_in=31, h_in=2 with MAX_W=16 -> 32 DRAW cycles, x spans x0..x0+15.
//  5 go re-pulsed mid-draw -> ignored, pixel stream unchanged; resetn low at pixel 5 -> all outputs 0 next edge,
//    no done; new go after release draws cleanly.
//  6 RECT_OUTLINE_EN, outline=1, 4x4 -> 16 DRAW cycles, 12 plot pulses, interior (1..2,1..2) offsets not plotted.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared VGA screen geometry, colour names and draw FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int VGA_X_W      = 8;
    localparam int VGA_Y_W      = 7;
    localparam int VGA_COLOUR_W = 3;
    localparam int VGA_SCREEN_W = 160;
    localparam int VGA_SCREEN_H = 120;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } draw_state_t;

endpackage

`default_nettype wire

// File: rtl/rect_scan_counter.sv
// ============================================================================
// Module  : rect_scan_counter
// Brief   : Raster offset generator; reports the pixel issued this cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_scan_counter #(
    parameter int WW = 5,
    parameter int HW = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          step,
    input  logic [WW-1:0] w_load,
    input  logic [HW-1:0] h_load,
    output logic [WW-1:0] xoff,
    output logic [HW-1:0] yoff,
    output logic          last_pixel,
    output logic          first_col,
    output logic          last_col,
    output logic          first_row,
    output logic          last_row
);

    localparam logic [WW-1:0] ONE_X = 1;
    localparam logic [HW-1:0] ONE_Y = 1;

    // r_cx/r_cy hold the offset that the next step will issue.
    logic [WW-1:0] r_cx;
    logic [WW-1:0] r_w;
    logic [HW-1:0] r_cy;
    logic [HW-1:0] r_h;
    logic [WW-1:0] lim_w;
    logic [HW-1:0] lim_h;

    always_comb begin
        xoff       = load ? '0 : r_cx;
        yoff       = load ? '0 : r_cy;
        lim_w      = load ? w_load : r_w;
        lim_h      = load ? h_load : r_h;
        first_col  = (xoff == '0);
        first_row  = (yoff == '0);
        last_col   = (xoff == lim_w - ONE_X);
        last_row   = (yoff == lim_h - ONE_Y);
        last_pixel = last_col && last_row;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cx <= '0;
            r_cy <= '0;
            r_w  <= '0;
            r_h  <= '0;
        end else if (load || step) begin
            if (load) begin
                r_w <= w_load;
                r_h <= h_load;
            end
            if (last_col) begin
                r_cx <= '0;
                r_cy <= yoff + ONE_Y;
            end else begin
                r_cx <= xoff + ONE_X;
                r_cy <= yoff;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rect_plotter.sv
// ============================================================================
// Module  : rect_plotter
// Brief   : Streams a clipped rectangle, one pixel per clock, to vga_adapter.
//           Optional border-only mode when RECT_OUTLINE_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_plotter
    import vga_pkg::*;
#(
    parameter int X_W      = VGA_X_W,
    parameter int Y_W      = VGA_Y_W,
    parameter int COLOUR_W = VGA_COLOUR_W,
    parameter int MAX_W    = 16,
    parameter int MAX_H    = 16,
    parameter int SCREEN_W = VGA_SCREEN_W,
    parameter int SCREEN_H = VGA_SCREEN_H
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         go,
    input  logic [X_W-1:0]               x_in,
    input  logic [Y_W-1:0]               y_in,
    input  logic [$clog2(MAX_W+1)-1:0]   w_in,
    input  logic [$clog2(MAX_H+1)-1:0]   h_in,
    input  logic [COLOUR_W-1:0]          colour_in,
`ifdef RECT_OUTLINE_EN
    input  logic                         outline,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [X_W-1:0]               x_out,
    output logic [Y_W-1:0]               y_out,
    output logic [COLOUR_W-1:0]          colour_out,
    output logic                         plot
);

    localparam int WW = $clog2(MAX_W+1);
    localparam int HW = $clog2(MAX_H+1);
    localparam logic [WW-1:0]  MAX_W_L = MAX_W[WW-1:0];
    localparam logic [HW-1:0]  MAX_H_L = MAX_H[HW-1:0];
    localparam logic [X_W:0]   SCR_W_L = SCREEN_W[X_W:0];
    localparam logic [Y_W:0]   SCR_H_L = SCREEN_H[Y_W:0];

    draw_state_t         r_state, nxt_state;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_outline;
    logic                r_last;

    logic                nxt_busy, nxt_done, nxt_plot, nxt_last;
    logic [X_W-1:0]      nxt_x;
    logic [Y_W-1:0]      nxt_y;
    logic [COLOUR_W-1:0] nxt_colour;

    logic                w_outline;
    logic [WW-1:0]       w_sat;
    logic [HW-1:0]       h_sat;
    logic                accept, zero_size, load, step, issue;
    logic [WW-1:0]       xoff;
    logic [HW-1:0]       yoff;
    logic                last_pixel, first_col, last_col, first_row, last_row;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                on_screen, on_border, outl_sel;

`ifdef RECT_OUTLINE_EN
    assign w_outline = outline;
`else
    assign w_outline = 1'b0;
`endif

    assign w_sat     = (w_in > MAX_W_L) ? MAX_W_L : w_in;
    assign h_sat     = (h_in > MAX_H_L) ? MAX_H_L : h_in;
    assign accept    = (r_state == S_IDLE) && go;
    assign zero_size = (w_sat == '0) || (h_sat == '0);
    assign load      = accept && !zero_size;
    assign step      = (r_state == S_DRAW) && !r_last;
    assign issue     = load || step;

    rect_scan_counter #(
        .WW (WW),
        .HW (HW)
    ) u_scan (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .step       (step),
        .w_load     (w_sat),
        .h_load     (h_sat),
        .xoff       (xoff),
        .yoff       (yoff),
        .last_pixel (last_pixel),
        .first_col  (first_col),
        .last_col   (last_col),
        .first_row  (first_row),
        .last_row   (last_row)
    );

    // The first pixel uses the live inputs since they are latched on the same edge.
    always_comb begin
        sum_x     = {1'b0, (load ? x_in : r_x0)} + {{(X_W+1-WW){1'b0}}, xoff};
        sum_y     = {1'b0, (load ? y_in : r_y0)} + {{(Y_W+1-HW){1'b0}}, yoff};
        outl_sel  = load ? w_outline : r_outline;
        on_screen = (sum_x < SCR_W_L) && (sum_y < SCR_H_L);
        on_border = !outl_sel || first_col || last_col || first_row || last_row;
    end

    always_comb begin
        nxt_state  = r_state;
        nxt_busy   = 1'b0;
        nxt_done   = 1'b0;
        nxt_plot   = 1'b0;
        nxt_last   = r_last;
        nxt_x      = x_out;
        nxt_y      = y_out;
        nxt_colour = colour_out;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    nxt_busy = 1'b1;
                    if (zero_size) begin
                        nxt_state = S_DONE;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_state = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                nxt_busy = 1'b1;
                if (r_last) begin
                    nxt_state = S_DONE;
                    nxt_done  = 1'b1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
        if (issue) begin
            nxt_x      = sum_x[X_W-1:0];
            nxt_y      = sum_y[Y_W-1:0];
            nxt_colour = load ? colour_in : r_colour;
            nxt_plot   = on_screen && on_border;
            nxt_last   = last_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_x0       <= '0;
            r_y0       <= '0;
            r_colour   <= '0;
            r_outline  <= 1'b0;
            r_last     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
        end else begin
            r_state    <= nxt_state;
            r_last     <= nxt_last;
            busy       <= nxt_busy;
            done       <= nxt_done;
            plot       <= nxt_plot;
            x_out      <= nxt_x;
            y_out      <= nxt_y;
            colour_out <= nxt_colour;
            if (accept) begin
                r_x0      <= x_in;
                r_y0      <= y_in;
                r_colour  <= colour_in;
                r_outline <= w_outline;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rect_plotter.sv
// ============================================================================
// Module  : tb_rect_plotter
// Brief   : Directed scoreboard bench for rect_plotter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rect_plotter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       go;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [4:0] w_in;
    logic [4:0] h_in;
    logic [2:0] colour_in;
    logic       outline;
    logic       busy, done, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    px_t sb[$];

    always #5 clk = ~clk;

    rect_plotter dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .x_in       (x_in),
        .y_in       (y_in),
        .w_in       (w_in),
        .h_in       (h_in),
        .colour_in  (colour_in),
`ifdef RECT_OUTLINE_EN
        .outline    (outline),
`endif
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference raster: every DRAW cycle gets one entry, clipped or not.
    task automatic push_model(input int x, input int y, input int w, input int h,
                              input int col, input bit outl, output int n);
        int  ws = (w > 16) ? 16 : w;
        int  hs = (h > 16) ? 16 : h;
        int  sx, sy;
        px_t e;
        n = ws * hs;
        for (int yo = 0; yo < hs; yo++) begin
            for (int xo = 0; xo < ws; xo++) begin
                sx     = x + xo;
                sy     = y + yo;
                e.plot = (sx < 160) && (sy < 120) &&
                         (!outl || xo == 0 || xo == ws - 1 || yo == 0 || yo == hs - 1);
                e.x    = sx[7:0];
                e.y    = sy[6:0];
                e.c    = col[2:0];
                sb.push_back(e);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the first busy cycle.
    task automatic start_rect(input int x, input int y, input int w, input int h,
                              input int col, input bit outl, output int n);
        push_model(x, y, w, h, col, outl, n);
        x_in      = x[7:0];
        y_in      = y[6:0];
        w_in      = w[4:0];
        h_in      = h[4:0];
        colour_in = col[2:0];
        outline   = outl;
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
    endtask

    task automatic run_check(input int n, input int repulse_k, input int stop_k,
                             output int plots);
        px_t e;
        plots = 0;
        if (n == 0) begin
            chk("zero_busy", busy, 1);
            chk("zero_done", done, 1);
            chk("zero_plot", plot, 0);
            @(negedge clk);
            chk("zero_busy_after", busy, 0);
            chk("zero_done_after", done, 0);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            go = (k == repulse_k);
            if (k == repulse_k) begin
                x_in = 8'd3; y_in = 7'd3; w_in = 5'd2; h_in = 5'd2; colour_in = 3'b111;
            end
            chk("draw_busy", busy, 1);
            chk("draw_done", done, 0);
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("px_plot", plot, e.plot);
                chk("px_x", x_out, e.x);
                chk("px_y", y_out, e.y);
                if (e.plot) chk("px_colour", colour_out, e.c);
            end
            if (plot === 1'b1) plots++;
            if (k == stop_k) return;
            @(negedge clk);
        end
        go = 1'b0;
        chk("end_done", done, 1);
        chk("end_busy", busy, 1);
        chk("end_plot", plot, 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int n, plots;
        resetn = 1'b0; go = 1'b0; outline = 1'b0;
        x_in = '0; y_in = '0; w_in = '0; h_in = '0; colour_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_plot", plot, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_colour", colour_out, 0);
        resetn = 1'b1;
        @(negedge clk);

        // 4x4 filled at (37,85)
        start_rect(37, 85, 4, 4, 4, 1'b0, n);
        run_check(n, 0, 0, plots);
        chk("t1_plots", plots, 16);

        // zero-size requests in both dimensions
        start_rect(10, 10, 0, 5, 2, 1'b0, n);
        run_check(n, 0, 0, plots);
        start_rect(10, 10, 5, 0, 2, 1'b0, n);
        run_check(n, 0, 0, plots);

        // bottom-right corner clipping
        start_rect(158, 118, 4, 4, 6, 1'b0, n);
        run_check(n, 0, 0, plots);
        chk("t3_plots", plots, 4);

        // width saturation
        start_rect(10, 20, 31, 2, 1, 1'b0, n);
        chk("t4_cycles", n, 32);
        run_check(n, 0, 0, plots);
        chk("t4_plots", plots, 32);

        // 1x1 with go re-pulsed mid-draw on a larger one
        start_rect(0, 0, 1, 1, 7, 1'b0, n);
        run_check(n, 0, 0, plots);
        start_rect(50, 60, 3, 3, 5, 1'b0, n);
        run_check(n, 4, 0, plots);
        chk("t5_plots", plots, 9);

        // reset at pixel 5 abandons the draw
        start_rect(37, 85, 4, 4, 3, 1'b0, n);
        run_check(n, 0, 5, plots);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_plot", plot, 0);
        chk("mrst_x", x_out, 0);
        chk("mrst_y", y_out, 0);
        chk("mrst_colour", colour_out, 0);
        @(negedge clk);
        chk("mrst_no_done", done, 0);
        chk("mrst_idle_busy", busy, 0);
        sb.delete();
        start_rect(100, 40, 2, 3, 2, 1'b0, n);
        run_check(n, 0, 0, plots);
        chk("t5b_plots", plots, 6);

`ifdef RECT_OUTLINE_EN
        start_rect(20, 30, 4, 4, 5, 1'b1, n);
        run_check(n, 0, 0, plots);
        chk("t6_plots", plots, 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
